// File: rtl/burst_line_buffer.sv
// burst_line_buffer
//   Bridge between the L2 downstream port (whole-line requests) and the burst
//   memory interface (BEAT_BITS beats). Writes are posted into a small FIFO
//   write-back buffer and drained in bursts when the L2 side is quiet or
//   the buffer is full. Reads that hit a buffered line are forwarded from the
//   buffer. Writes to an already buffered line are coalesced into that entry.
//   Read beats are accepted only while a read burst is outstanding and only
//   when their address tag matches the request.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   l2_addr/read/write/wdata L2 request, held until l2_resp
//   l2_rdata, l2_resp        read line and one-cycle completion pulse
//   bmem_addr/read           line-aligned request address, read request
//   bmem_write/wdata         write beat valid and data
//   bmem_ready               memory accepts request/beat this cycle
//   bmem_raddr/rdata/rvalid  returning read beat with its address tag
module burst_line_buffer #(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64,
  parameter int WB_DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] l2_addr,
  input  logic                 l2_read,
  input  logic                 l2_write,
  input  logic [LINE_BITS-1:0] l2_wdata,
  output logic [LINE_BITS-1:0] l2_rdata,
  output logic                 l2_resp,
  output logic [ADDR_BITS-1:0] bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_BITS-1:0] bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [ADDR_BITS-1:0] bmem_raddr,
  input  logic [BEAT_BITS-1:0] bmem_rdata,
  input  logic                 bmem_rvalid
);

  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int BW    = $clog2(BEATS);
  localparam int PW    = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int CW    = $clog2(WB_DEPTH + 1);

  localparam logic [ADDR_BITS-1:0] AMASK     = {ADDR_BITS{1'b1}} << OFF;
  localparam logic [BW-1:0]        LAST_BEAT = BW'(BEATS - 1);
  localparam logic [CW-1:0]        FULL_CNT  = CW'(WB_DEPTH);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_BURST, RESP} state_t;

  state_t state, state_nxt;

  logic [ADDR_BITS-1:0] req_addr;
  logic [BW-1:0]        beat, beat_inc;

  logic [WB_DEPTH-1:0]                wb_vld;
  logic [WB_DEPTH-1:0][ADDR_BITS-1:0] wb_addr;
  logic [WB_DEPTH-1:0][LINE_BITS-1:0] wb_data;
  logic [PW-1:0]                      head, tail;
  logic [CW-1:0]                      wb_count;

  logic [ADDR_BITS-1:0] l2_aligned;
  logic [WB_DEPTH-1:0]  hit_vec, coal_vec;
  logic [PW-1:0]        hit_idx, coal_idx;
  logic                 any_hit, any_coal, wb_full, raddr_match;

  logic take_hit, take_miss, take_coal, take_alloc, rd_beat, wr_beat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign l2_aligned  = l2_addr & AMASK;
  assign raddr_match = (bmem_raddr & AMASK) == req_addr;
  assign wb_full     = wb_count == FULL_CNT;
  assign beat_inc    = (beat == LAST_BEAT) ? '0 : beat + 1'b1;

  // Per-entry address compare. The head entry is excluded from coalescing
  // while it is being burst out, since its beats are already on the bus.
  for (genvar i = 0; i < WB_DEPTH; i++) begin : g_cmp
    assign hit_vec[i]  = wb_vld[i] && (wb_addr[i] == l2_aligned);
    assign coal_vec[i] = hit_vec[i] && !(state == WR_BURST && head == PW'(i));
  end

  assign any_hit  = |hit_vec;
  assign any_coal = |coal_vec;

  always_comb begin
    hit_idx  = '0;
    coal_idx = '0;
    for (int i = WB_DEPTH - 1; i >= 0; i--) begin
      if (hit_vec[i])  hit_idx  = PW'(i);
      if (coal_vec[i]) coal_idx = PW'(i);
    end
  end

  // Next state and one-cycle action strobes
  always_comb begin
    state_nxt  = state;
    take_hit   = 1'b0;
    take_miss  = 1'b0;
    take_coal  = 1'b0;
    take_alloc = 1'b0;
    rd_beat    = 1'b0;
    wr_beat    = 1'b0;
    case (state)
      IDLE: begin
        if (l2_read) begin
          if (any_hit) begin
            take_hit  = 1'b1;
            state_nxt = RESP;
          end else begin
            // Miss already proved no buffered copy, so it may pass the writes
            take_miss = 1'b1;
            state_nxt = RD_REQ;
          end
        end else if (l2_write) begin
          if (any_coal) begin
            take_coal = 1'b1;
            state_nxt = RESP;
          end else if (!wb_full) begin
            take_alloc = 1'b1;
            state_nxt  = RESP;
          end else begin
            // Full: free the head first, the held write is retaken in IDLE
            state_nxt = WR_BURST;
          end
        end else if (wb_count != '0) begin
          state_nxt = WR_BURST;
        end
      end
      RD_REQ: if (bmem_ready) state_nxt = RD_DATA;
      RD_DATA: begin
        if (bmem_rvalid && raddr_match) begin
          rd_beat = 1'b1;
          if (beat == LAST_BEAT) state_nxt = RESP;
        end
      end
      WR_BURST: begin
        if (bmem_ready) begin
          wr_beat = 1'b1;
          if (beat == LAST_BEAT) state_nxt = IDLE;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      req_addr <= '0;
      beat     <= '0;
      l2_resp  <= 1'b0;
      l2_rdata <= '0;
      wb_vld   <= '0;
      wb_addr  <= '0;
      wb_data  <= '0;
      head     <= '0;
      tail     <= '0;
      wb_count <= '0;
    end else begin
      state   <= state_nxt;
      l2_resp <= state_nxt == RESP;
      if (take_miss) begin
        req_addr <= l2_aligned;
        beat     <= '0;
      end
      if (take_hit) l2_rdata <= wb_data[hit_idx];
      if (rd_beat) begin
        l2_rdata[beat*BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
        beat <= beat_inc;
      end
      if (take_coal) wb_data[coal_idx] <= l2_wdata;
      if (take_alloc) begin
        wb_vld[tail]  <= 1'b1;
        wb_addr[tail] <= l2_aligned;
        wb_data[tail] <= l2_wdata;
        tail          <= ptr_inc(tail);
        wb_count      <= wb_count + 1'b1;
      end
      if (wr_beat) begin
        beat <= beat_inc;
        if (beat == LAST_BEAT) begin
          wb_vld[head] <= 1'b0;
          head         <= ptr_inc(head);
          wb_count     <= wb_count - 1'b1;
        end
      end
    end
  end

  assign bmem_read  = state == RD_REQ;
  assign bmem_write = state == WR_BURST;
  assign bmem_addr  = (state == RD_REQ)   ? req_addr :
                      (state == WR_BURST) ? wb_addr[head] : '0;
  assign bmem_wdata = (state == WR_BURST) ? wb_data[head][beat*BEAT_BITS +: BEAT_BITS] : '0;

  // Simultaneous read and write from L2 is a protocol error
  a_no_rd_wr: assert property (@(posedge clk) disable iff (!rst)
    !(state == IDLE && l2_read && l2_write));

endmodule

// File: tb/tb_burst_line_buffer.sv
// Directed bench for burst_line_buffer (default parameters: 32-bit address,
// 256-bit line, 64-bit beat, 2 buffer entries). Inputs are driven and outputs
// sampled on the falling clock edge.
module tb_burst_line_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  l2_addr;
  logic         l2_read, l2_write;
  logic [255:0] l2_wdata, l2_rdata;
  logic         l2_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int n_assert = 0;
  int n_fail   = 0;

  burst_line_buffer dut (
    .clk(clk), .rst(rst),
    .l2_addr(l2_addr), .l2_read(l2_read), .l2_write(l2_write),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line whose beat k is {t, 56'dk}
  function automatic logic [255:0] mk(input logic [7:0] t);
    return {t, 56'd3, t, 56'd2, t, 56'd1, t, 56'd0};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_resp(input string tag, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!l2_resp && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, l2_resp, 1'b1);
  endtask

  // Expect one full drain burst of the given line, memory always ready
  task automatic drain_expect(input string tag, input logic [31:0] addr, input logic [255:0] line);
    int n;
    bmem_ready = 1'b1;
    n = 0;
    while (!bmem_write && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, bmem_write, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_addr"}, bmem_addr, addr);
      chk({tag, "_beat"}, bmem_wdata, line[k*64 +: 64]);
      @(negedge clk);
    end
    chk({tag, "_end"}, bmem_write, 1'b0);
  endtask

  // Read miss with memory ready; optional stray beats in RD_REQ and mid-burst
  task automatic rd_miss(input string tag, input logic [31:0] addr,
                         input logic [255:0] line, input bit stray);
    @(negedge clk);
    l2_addr = addr; l2_read = 1'b1; bmem_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_bmem_read"}, bmem_read, 1'b1);
    chk({tag, "_bmem_addr"}, bmem_addr, addr);
    if (stray) begin
      bmem_rvalid = 1'b1; bmem_raddr = addr; bmem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    @(negedge clk);
    bmem_rvalid = 1'b0;
    chk({tag, "_read_1cyc"}, bmem_read, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (stray && k == 2) begin
        bmem_rvalid = 1'b1; bmem_raddr = 32'h9999_0000; bmem_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
        @(negedge clk);
      end
      bmem_rvalid = 1'b1; bmem_raddr = addr; bmem_rdata = line[k*64 +: 64];
      @(negedge clk);
    end
    bmem_rvalid = 1'b0; bmem_raddr = '0; bmem_rdata = '0;
    chk({tag, "_resp"}, l2_resp, 1'b1);
    chk({tag, "_rdata"}, l2_rdata, line);
    l2_read = 1'b0;
    @(negedge clk);
    chk({tag, "_resp_pulse"}, l2_resp, 1'b0);
  endtask

  initial begin
    int  saw;
    rst = 1'b0;
    l2_addr = '0; l2_read = 1'b0; l2_write = 1'b0; l2_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;

    // Reset state
    #1;
    chk("rst_resp",  l2_resp,    1'b0);
    chk("rst_rdata", l2_rdata,   256'd0);
    chk("rst_read",  bmem_read,  1'b0);
    chk("rst_write", bmem_write, 1'b0);
    chk("rst_addr",  bmem_addr,  32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Read miss, clean beats
    rd_miss("miss", 32'h0000_1040, mk(8'hA0), 1'b0);

    // Write then read-hit forwarded from the buffer, memory stalled
    @(negedge clk);
    bmem_ready = 1'b0;
    l2_addr = 32'h0000_2000; l2_wdata = mk(8'hD0); l2_write = 1'b1;
    @(negedge clk);
    chk("wr_resp", l2_resp, 1'b1);
    l2_write = 1'b0; l2_read = 1'b1;
    @(negedge clk);
    chk("hit_idle", l2_resp, 1'b0);
    @(negedge clk);
    chk("hit_resp",    l2_resp,   1'b1);
    chk("hit_rdata",   l2_rdata,  mk(8'hD0));
    chk("hit_no_read", bmem_read, 1'b0);
    l2_read = 1'b0;
    drain_expect("drain_2000", 32'h0000_2000, mk(8'hD0));

    // Fill the buffer with memory stalled; third write waits for a drain
    @(negedge clk);
    bmem_ready = 1'b0;
    l2_addr = 32'h0000_0100; l2_wdata = mk(8'h11); l2_write = 1'b1;
    wait_resp("full_w1", 10);
    l2_addr = 32'h0000_0200; l2_wdata = mk(8'h22);
    wait_resp("full_w2", 10);
    l2_addr = 32'h0000_0300; l2_wdata = mk(8'h33);
    saw = 0;
    repeat (10) begin
      @(negedge clk);
      if (l2_resp) saw++;
    end
    chk("full_withheld", saw, 0);
    chk("full_drain_wr", bmem_write, 1'b1);
    chk("full_drain_ad", bmem_addr, 32'h0000_0100);
    drain_expect("drain_100", 32'h0000_0100, mk(8'h11));
    wait_resp("full_w3", 10);
    l2_write = 1'b0;
    drain_expect("drain_200", 32'h0000_0200, mk(8'h22));
    drain_expect("drain_300", 32'h0000_0300, mk(8'h33));

    // Coalesce: two writes to one line leave a single entry carrying Y
    bmem_ready = 1'b0;
    l2_addr = 32'h0000_0400; l2_wdata = mk(8'h58); l2_write = 1'b1;
    wait_resp("coal_w1", 10);
    l2_addr = 32'h0000_0410; l2_wdata = mk(8'h59);
    wait_resp("coal_w2", 10);
    l2_write = 1'b0;
    drain_expect("drain_400", 32'h0000_0400, mk(8'h59));
    saw = 0;
    repeat (6) begin
      @(negedge clk);
      if (bmem_write) saw++;
    end
    chk("coal_single", saw, 0);

    // Stray beats before RD_DATA and with a foreign tag mid-burst
    rd_miss("stray", 32'h0000_3000, mk(8'hB0), 1'b1);

    // Reset in the middle of a drain burst
    @(negedge clk);
    bmem_ready = 1'b0;
    l2_addr = 32'h0000_0500; l2_wdata = mk(8'hC5); l2_write = 1'b1;
    wait_resp("rst_wr", 10);
    l2_write = 1'b0;
    bmem_ready = 1'b1;
    saw = 0;
    while (!bmem_write && saw < 20) begin
      @(negedge clk);
      saw++;
    end
    chk("rst_drain_start", bmem_write, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_beat2", bmem_wdata, 64'hC500_0000_0000_0002);
    rst = 1'b0;
    #1;
    chk("rst_mid_write", bmem_write, 1'b0);
    chk("rst_mid_addr",  bmem_addr,  32'd0);
    chk("rst_mid_wdata", bmem_wdata, 64'd0);
    chk("rst_mid_rdata", l2_rdata,   256'd0);
    chk("rst_mid_resp",  l2_resp,    1'b0);
    @(negedge clk);
    rst = 1'b1;
    saw = 0;
    repeat (8) begin
      @(negedge clk);
      if (bmem_write || bmem_read) saw++;
    end
    chk("rst_buffer_empty", saw, 0);

    // Fresh write after reset drains normally
    l2_addr = 32'h0000_0600; l2_wdata = mk(8'hE6); l2_write = 1'b1;
    wait_resp("post_rst_wr", 10);
    l2_write = 1'b0;
    drain_expect("drain_600", 32'h0000_0600, mk(8'hE6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_line_buffer.md
Name: burst_line_buffer

Overview:
Parametrised line-to-burst bridge between the unified L2 cache's downstream port and the burst memory interface. It succeeds the fixed 256/64-bit line buffer and generalises line width, beat width and address width. New over the fixed buffer: a posted write-back buffer of WB_DEPTH entries, read-after-write forwarding, same-address write coalescing and filtering of stray read returns. It sits between l2cache and the chip-level memory pins.

Parameters:
ADDR_BITS, 32, address width of both sides
LINE_BITS, 256, cache line width; must be a multiple of BEAT_BITS
BEAT_BITS, 64, memory data beat width; BEATS = LINE_BITS/BEAT_BITS, at least 2
WB_DEPTH, 2, write-back buffer entries, at least 1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
l2_addr  in  ADDR_BITS  line address from L2
l2_read  in  1  read request, held until l2_resp
l2_write  in  1  write request, held until l2_resp
l2_wdata  in  LINE_BITS  write line
l2_rdata  out  LINE_BITS  read line, valid with l2_resp
l2_resp  out  1  one-cycle completion pulse
bmem_addr  out  ADDR_BITS  line-aligned memory address
bmem_read  out  1  read request
bmem_write  out  1  write beat valid
bmem_wdata  out  BEAT_BITS  write beat
bmem_ready  in  1  memory accepts request/beat this cycle
bmem_raddr  in  ADDR_BITS  address tag of returning beat
bmem_rdata  in  BEAT_BITS  read beat
bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0. FSM goes to IDLE, beat counters clear and the write buffer empties; buffered dirty lines are discarded. Reset mid-burst abandons the burst.
- Address alignment: the low log2(LINE_BITS/8) bits are zeroed on bmem_addr and in all address compares.
- FSM states: IDLE, RD_REQ, RD_DATA, WR_BURST, RESP.
- IDLE priority, highest first: (1) l2_read; (2) l2_write; (3) buffer non-empty, which starts a drain (WR_BURST). If l2_read and l2_write are both high, read wins; this case is illegal and flagged by an assertion.
- Requests are sampled only in IDLE. l2_resp is registered. IDLE is re-entered in the cycle after l2_resp, so a request still high during the resp cycle is not re-accepted.
- Read hit, where the aligned address matches a valid buffer entry: go to RESP, with l2_rdata set to the entry data. l2_resp is asserted 1 cycle after sampling. No memory access occurs.
- Read miss: enter RD_REQ and assert bmem_read with bmem_addr until a cycle with bmem_ready=1, then enter RD_DATA. Accept beats only when bmem_rvalid=1 and bmem_raddr equals the request address. Beat k fills bits [k*BEAT_BITS +: BEAT_BITS], k=0..BEATS-1. After the last beat, go to RESP. l2_resp is asserted the cycle after the last beat.
- Stray rvalid: a beat with a mismatching raddr, or one arriving outside RD_DATA, is ignored.
- Single outstanding read. A read miss may overtake buffered writes because the address was already checked for no match.
- Write, coalesce case: the address matches a buffer entry that is not draining. Overwrite that entry in place; l2_resp follows 1 cycle later.
- Write, allocate case: otherwise allocate the tail entry if the buffer is not full, and l2_resp follows 1 cycle later. If the buffer is full, the write is not accepted; the FSM drains the head entry first, then accepts.
- WR_BURST: drains the head entry. bmem_write=1 with bmem_addr=entry address and bmem_wdata=beat k. k advances only on bmem_ready=1. After BEATS accepted beats, the entry is popped and the FSM returns to IDLE. A drain burst is never interrupted.
- A draining entry still forwards to reads until it is popped.
- Forwarding and coalescing compare all valid entries. At most one entry per address is not draining.
- Buffer count: 0..WB_DEPTH. Pointers wrap modulo WB_DEPTH.

Test Plan:
- Read miss, addr 0x0000_1040, memory returns 4 beats A0..A3 with raddr 0x0000_1040 and ready=1 -> bmem_read for 1 cycle at 0x0000_1040; l2_rdata={A3,A2,A1,A0}; l2_resp 1 cycle after the last beat.
- Write 0x2000 data D, then read 0x2000 before the drain -> l2_resp 1 cycle after the read is sampled; l2_rdata=D; no bmem_read.
- WB_DEPTH=2: write 0x100, then 0x200, then 0x300 with bmem_ready=0 -> third l2_resp withheld; raise ready -> 4 beats at 0x100, then third resp.
- Write 0x400=X, then 0x400=Y back-to-back -> count stays 1; the drained beats carry Y.
- During RD_DATA, inject rvalid with raddr 0x9999_0000 -> ignored; data still assembles from matching beats.
- Assert rst low mid WR_BURST (beat 2) -> outputs 0 immediately; after release, no bmem_write until a new l2_write.
